// File: rtl/dmem_responder.sv
// Word-addressed 64-bit data memory with valid/ready request and response channels,
// fixed access latency and one transaction in flight. Optional DMEM_PERF_CNT_EN adds
// saturating load/store/error counters.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_errors
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [63:0]        wdata_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic [63:0]        resp_rdata_q;
    logic               resp_error_q;
    logic [63:0]        mem_q [DEPTH];

    logic               req_err_s;
    logic               cap_en_s;
    logic               commit_s;
    logic               resp_done_s;
    logic               cmt_write_s;
    logic               cmt_err_s;
    logic [IDX_W-1:0]   cmt_idx_s;
    logic [63:0]        cmt_wdata_s;

    // Next-state decode; the commit operands come straight from the request when LATENCY is 1
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_en_s    = 1'b0;
        commit_s    = 1'b0;
        resp_done_s = 1'b0;
        req_err_s   = (req_addr >= 64'(DEPTH));
        cmt_write_s = wr_q;
        cmt_err_s   = err_q;
        cmt_idx_s   = idx_q;
        cmt_wdata_s = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cap_en_s    = 1'b1;
                    cmt_write_s = req_write;
                    cmt_err_s   = req_err_s;
                    cmt_idx_s   = req_addr[IDX_W-1:0];
                    cmt_wdata_s = req_wdata;
                    if (LATENCY == 1) begin
                        state_d  = S_RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d     = S_IDLE;
                    resp_done_s = 1'b1;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, latency counter and captured request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 64'd0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == S_IDLE);
            if (cap_en_s) begin
                wr_q    <= req_write;
                err_q   <= req_err_s;
                idx_q   <= req_addr[IDX_W-1:0];
                wdata_q <= req_wdata;
            end
        end
    end

    // Word array; only error-free stores write, and only on the commit edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else if (commit_s && cmt_write_s && !cmt_err_s) begin
            mem_q[cmt_idx_s] <= cmt_wdata_s;
        end
    end

    // Registered response, held until the requester takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_error_q <= 1'b0;
        end else if (commit_s) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= cmt_err_s;
            resp_rdata_q <= (!cmt_write_s && !cmt_err_s) ? mem_q[cmt_idx_s] : 64'd0;
        end else if (resp_done_s) begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 64'd0;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_loads_q;
    logic [31:0] perf_stores_q;
    logic [31:0] perf_errors_q;

    // One saturating counter per commit; errors win over the access type
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_loads_q  <= 32'd0;
            perf_stores_q <= 32'd0;
            perf_errors_q <= 32'd0;
        end else if (commit_s) begin
            if (cmt_err_s) begin
                if (perf_errors_q != 32'hFFFF_FFFF) perf_errors_q <= perf_errors_q + 32'd1;
            end else if (cmt_write_s) begin
                if (perf_stores_q != 32'hFFFF_FFFF) perf_stores_q <= perf_stores_q + 32'd1;
            end else begin
                if (perf_loads_q != 32'hFFFF_FFFF) perf_loads_q <= perf_loads_q + 32'd1;
            end
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_errors = perf_errors_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (DEPTH=256, LATENCY=2).
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_errors;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_ld = 0;
    int exp_st = 0;
    int exp_er = 0;
    int acc_cyc;

    dmem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
`ifdef DMEM_PERF_CNT_EN
        ,
        .perf_loads (perf_loads),
        .perf_stores(perf_stores),
        .perf_errors(perf_errors)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] er;
        logic        ee;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d, input string nm);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " req_ready before issue"}, req_ready, 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] er, input logic ee, input string nm);
        int lat;
        issue(w, a, d, nm);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(LAT));
        chk({nm, " rdata"}, resp_rdata, er);
        chk({nm, " error"}, resp_error, 64'(ee));
        chk({nm, " req_ready in resp"}, req_ready, 64'd0);
        if (ee) exp_er++;
        else if (w) exp_st++;
        else exp_ld++;
        @(negedge clk);
        chk({nm, " resp_valid cleared"}, resp_valid, 64'd0);
        chk({nm, " rdata cleared"}, resp_rdata, 64'd0);
    endtask

    initial begin
        int prev_acc;
        logic [63:0] held;

        tbl[0]  = '{1'b1, 64'h10,                  64'hDEADBEEFCAFEF00D, 64'h0,                1'b0};
        tbl[1]  = '{1'b0, 64'h10,                  64'h0,                64'hDEADBEEFCAFEF00D, 1'b0};
        tbl[2]  = '{1'b0, 64'h100,                 64'h0,                64'h0,                1'b1};
        tbl[3]  = '{1'b1, 64'hFFFFFFFFFFFFFFF8,    64'h1,                64'h0,                1'b1};
        tbl[4]  = '{1'b0, 64'hF8,                  64'h0,                64'h0,                1'b0};
        tbl[5]  = '{1'b1, 64'hFF,                  64'hA5A5A5A5_5A5A5A5A, 64'h0,               1'b0};
        tbl[6]  = '{1'b0, 64'hFF,                  64'h0,                64'hA5A5A5A5_5A5A5A5A, 1'b0};
        tbl[7]  = '{1'b0, 64'h8000000000000000,    64'h0,                64'h0,                1'b1};
        tbl[8]  = '{1'b1, 64'h10,                  64'h55,               64'h0,                1'b0};
        tbl[9]  = '{1'b0, 64'h10,                  64'h0,                64'h55,               1'b0};
        tbl[10] = '{1'b1, 64'h8000000000000000,    64'h77,               64'h0,                1'b1};
        tbl[11] = '{1'b0, 64'h0,                   64'h0,                64'h0,                1'b0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset req_ready", req_ready, 64'd0);
        chk("reset resp_valid", resp_valid, 64'd0);
        chk("reset resp_rdata", resp_rdata, 64'd0);
        chk("reset resp_error", resp_error, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("req_ready after reset", req_ready, 64'd1);
`ifdef DMEM_PERF_CNT_EN
        chk("perf loads reset", 64'(perf_loads), 64'd0);
        chk("perf stores reset", 64'(perf_stores), 64'd0);
        chk("perf errors reset", 64'(perf_errors), 64'd0);
`endif

        prev_acc = 0;
        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ee, $sformatf("vec%0d", i));
            if (i > 0) chk($sformatf("vec%0d spacing", i), 64'(acc_cyc - prev_acc), 64'(LAT + 1));
            prev_acc = acc_cyc;
        end
`ifdef DMEM_PERF_CNT_EN
        chk("perf loads", 64'(perf_loads), 64'(exp_ld));
        chk("perf stores", 64'(perf_stores), 64'(exp_st));
        chk("perf errors", 64'(perf_errors), 64'(exp_er));
`endif

        // Backpressured load with an intruding store request that must be ignored
        resp_ready = 1'b0;
        issue(1'b0, 64'h10, 64'h0, "hold");
        for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
        chk("hold rdata first", resp_rdata, 64'h55);
        held      = resp_rdata;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'h99;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk($sformatf("hold%0d resp_valid", n), resp_valid, 64'd1);
            chk($sformatf("hold%0d resp_rdata", n), resp_rdata, held);
            chk($sformatf("hold%0d resp_error", n), resp_error, 64'd0);
            chk($sformatf("hold%0d req_ready", n), req_ready, 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hold release resp_valid", resp_valid, 64'd0);
        chk("hold release req_ready", req_ready, 64'd1);
        txn(1'b0, 64'h20, 64'h0, 64'h0, 1'b0, "ignored store");

        // Reset while a store is waiting: no write, no response
        issue(1'b1, 64'h30, 64'h55, "abort");
        reset = 1'b1;
        @(negedge clk);
        chk("abort resp_valid in reset", resp_valid, 64'd0);
        chk("abort req_ready in reset", req_ready, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_ld = 0;
        exp_st = 0;
        exp_er = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk($sformatf("abort%0d no resp", n), resp_valid, 64'd0);
        end
`ifdef DMEM_PERF_CNT_EN
        chk("perf loads after reset", 64'(perf_loads), 64'd0);
        chk("perf stores after reset", 64'(perf_stores), 64'd0);
        chk("perf errors after reset", 64'(perf_errors), 64'd0);
`endif
        txn(1'b0, 64'h30, 64'h0, 64'h0, 1'b0, "aborted store");
        txn(1'b0, 64'h10, 64'h0, 64'h0, 1'b0, "cleared word");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
